hazard_forward_unit: RTL and testbench

- Control-side partner of the execute stage: produces the three 2-bit forward selects (val1/val2/val3) that the execute stage consumes, plus the pipeline stall for hazards forwarding cannot cover.
- Keeps its own shadow pipeline (EXE, MEM, WB slots) of register-use metadata, advanced in lockstep with the datapath pipeline registers.
- Sits beside the ID/EXE boundary. Inputs come from decode, the branch flush from EXE, and freeze from the memory controller.

---
 rtl/hazard_forward_unit.sv | 83 ++++++++
 tb/tb_hazard_forward_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forward-select generation and RAW hazard stall control with a shadow EXE/MEM/WB pipeline.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forward_en,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src2_alu,
    input  logic                  id_src2_read,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic                  flush,
    input  logic                  freeze,
    output logic [1:0]            val1_forward_sel,
    output logic [1:0]            val2_forward_sel,
    output logic [1:0]            val3_forward_sel,
    output logic                  hazard_stall,
    output logic [CNT_W-1:0]      stall_count
);
    logic [REG_ADDR_W-1:0] exe_src1, exe_src2, exe_dest, mem_dest, wb_dest;
    logic exe_src2_alu, exe_src2_read, exe_wb_en, exe_mem_r_en, mem_wb_en, wb_wb_en;
    logic s1_mem, s1_wb, s2_mem, s2_wb, i1_exe, i2_exe, i1_mem, i2_mem, take;

    function automatic logic hit(input logic [REG_ADDR_W-1:0] src, input logic wb,
                                 input logic [REG_ADDR_W-1:0] dest);
        return (src != '0) && wb && (dest == src);
    endfunction

    always_comb begin
        s1_mem = hit(exe_src1, mem_wb_en, mem_dest);
        s1_wb  = hit(exe_src1, wb_wb_en, wb_dest);
        s2_mem = hit(exe_src2, mem_wb_en, mem_dest);
        s2_wb  = hit(exe_src2, wb_wb_en, wb_dest);
        i1_exe = hit(id_src1, exe_wb_en, exe_dest);
        i2_exe = id_src2_read && hit(id_src2, exe_wb_en, exe_dest);
        i1_mem = hit(id_src1, mem_wb_en, mem_dest);
        i2_mem = id_src2_read && hit(id_src2, mem_wb_en, mem_dest);
        val1_forward_sel = !forward_en ? 2'b00 : s1_mem ? 2'b01 : s1_wb ? 2'b10 : 2'b00;
        val2_forward_sel = !(forward_en && exe_src2_alu) ? 2'b00 : s2_mem ? 2'b01 : s2_wb ? 2'b10 : 2'b00;
        val3_forward_sel = !(forward_en && exe_src2_read) ? 2'b00 : s2_mem ? 2'b01 : s2_wb ? 2'b10 : 2'b00;
        // With forwarding only a load in EXE cannot be bypassed in time
        hazard_stall = id_valid && !flush &&
                       (forward_en ? exe_mem_r_en && (i1_exe || i2_exe)
                                   : (i1_exe || i2_exe || i1_mem || i2_mem));
        take = id_valid && !flush && !hazard_stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exe_src1      <= '0;
            exe_src2      <= '0;
            exe_src2_alu  <= 1'b0;
            exe_src2_read <= 1'b0;
            exe_dest      <= '0;
            exe_wb_en     <= 1'b0;
            exe_mem_r_en  <= 1'b0;
            mem_dest      <= '0;
            mem_wb_en     <= 1'b0;
            wb_dest       <= '0;
            wb_wb_en      <= 1'b0;
            stall_count   <= '0;
        end else if (!freeze) begin
            exe_src1      <= take ? id_src1 : '0;
            exe_src2      <= take ? id_src2 : '0;
            exe_src2_alu  <= take && id_src2_alu;
            exe_src2_read <= take && id_src2_read;
            exe_dest      <= take ? id_dest : '0;
            exe_wb_en     <= take && id_wb_en;
            exe_mem_r_en  <= take && id_mem_r_en;
            mem_dest      <= exe_dest;
            mem_wb_en     <= exe_wb_en;
            wb_dest       <= mem_dest;
            wb_wb_en      <= mem_wb_en;
            if (hazard_stall && stall_count != '1)
                stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, stalls, freeze, flush, reset and counter saturation.
module tb_hazard_forward_unit;
    logic clk = 1'b0, rst, forward_en, id_valid, id_src2_alu, id_src2_read, id_wb_en, id_mem_r_en, flush, freeze;
    logic [4:0] id_src1, id_src2, id_dest;
    logic [1:0] v1, v2, v3, s1, s2, s3;
    logic stall, sat_stall;
    logic [15:0] count;
    logic [1:0] sat_count;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    hazard_forward_unit dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_alu(id_src2_alu),
        .id_src2_read(id_src2_read), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
        .val1_forward_sel(v1), .val2_forward_sel(v2), .val3_forward_sel(v3),
        .hazard_stall(stall), .stall_count(count)
    );

    // Narrow counter instance shares stimulus so saturation is reachable quickly
    hazard_forward_unit #(.REG_ADDR_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_src2_alu(id_src2_alu),
        .id_src2_read(id_src2_read), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .flush(flush), .freeze(freeze),
        .val1_forward_sel(s1), .val2_forward_sel(s2), .val3_forward_sel(s3),
        .hazard_stall(sat_stall), .stall_count(sat_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] a, input logic [4:0] b, input logic alu,
                          input logic rd, input logic [4:0] d, input logic wb, input logic mr);
        id_valid = v; id_src1 = a; id_src2 = b; id_src2_alu = alu;
        id_src2_read = rd; id_dest = d; id_wb_en = wb; id_mem_r_en = mr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (3) cyc();
    endtask

    initial begin
        rst = 1; forward_en = 1; flush = 0; freeze = 0;
        nop();
        repeat (2) cyc();
        rst = 0;
        #1;
        chk("reset_v1", v1, 0); chk("reset_v2", v2, 0); chk("reset_v3", v3, 0);
        chk("reset_stall", stall, 0); chk("reset_count", count, 0);

        // ADD r3,r1,r2 ; SUB r4,r3,r5
        set_id(1, 1, 2, 1, 1, 3, 1, 0); #1 chk("add_stall", stall, 0);
        cyc();
        set_id(1, 3, 5, 1, 1, 4, 1, 0); #1 chk("sub_stall", stall, 0);
        cyc();
        nop(); #1
        chk("sub_v1", v1, 2'b01); chk("sub_v2", v2, 2'b00); chk("sub_v3", v3, 2'b00); chk("sub_nostall", stall, 0);
        drain();

        // r3 producer, independent op, ST r3
        set_id(1, 1, 2, 1, 1, 3, 1, 0); cyc();
        set_id(1, 1, 2, 1, 1, 9, 1, 0); cyc();
        set_id(1, 1, 3, 0, 1, 0, 0, 0); cyc();
        nop(); #1
        chk("st_wb_v3", v3, 2'b10); chk("st_wb_v2", v2, 2'b00); chk("st_wb_v1", v1, 2'b00);
        drain();
        set_id(1, 1, 2, 1, 1, 3, 1, 0); cyc();
        set_id(1, 2, 1, 1, 1, 3, 1, 0); cyc();
        set_id(1, 1, 3, 0, 1, 0, 0, 0); cyc();
        nop(); #1
        chk("st_mem_v3", v3, 2'b01); chk("st_mem_v2", v2, 2'b00);
        drain();

        // LD r7 ; ADD r8,r7,r7
        set_id(1, 1, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 7, 7, 1, 1, 8, 1, 0); #1 chk("lu_stall1", stall, 1);
        cyc();
        #1 chk("lu_stall2", stall, 0); chk("lu_count", count, 1);
        cyc();
        nop(); #1
        chk("lu_v1", v1, 2'b10); chk("lu_v2", v2, 2'b10); chk("lu_after", stall, 0);
        drain();

        // Forwarding disabled: ADD/SUB pair stalls twice
        forward_en = 0;
        set_id(1, 1, 2, 1, 1, 3, 1, 0); cyc();
        set_id(1, 3, 5, 1, 1, 4, 1, 0); #1 chk("nf_stall1", stall, 1);
        cyc();
        #1 chk("nf_stall2", stall, 1);
        cyc();
        nop(); #1
        chk("nf_done", stall, 0); chk("nf_v1", v1, 0); chk("nf_v2", v2, 0); chk("nf_v3", v3, 0);
        chk("nf_count", count, 3);
        drain();
        set_id(1, 1, 2, 1, 1, 0, 1, 0); cyc();
        set_id(1, 0, 0, 1, 1, 5, 1, 0); #1 chk("r0_stall", stall, 0);
        cyc();
        nop(); forward_en = 1; #1
        chk("r0_v1", v1, 0); chk("r0_v2", v2, 0); chk("r0_v3", v3, 0);
        drain();

        // Freeze during a pending load-use
        set_id(1, 1, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 7, 2, 1, 1, 8, 1, 0); freeze = 1; #1 chk("fz_stall0", stall, 1);
        repeat (3) begin
            cyc();
            chk("fz_stall", stall, 1); chk("fz_count", count, 3); chk("fz_v1", v1, 0);
        end
        freeze = 0; #1 chk("fz_rel_stall", stall, 1);
        cyc();
        #1 chk("fz_after", stall, 0); chk("fz_count2", count, 4);
        cyc();
        nop(); #1 chk("fz_v1_fwd", v1, 2'b10);
        drain();

        // Flush together with a load-use hazard
        set_id(1, 1, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 7, 2, 1, 1, 8, 1, 0); flush = 1; #1 chk("fl_stall", stall, 0);
        cyc();
        flush = 0; nop(); #1
        chk("fl_count", count, 4); chk("fl_v1", v1, 0); chk("fl_stall2", stall, 0);
        drain();

        // Reset in the middle of a stall
        set_id(1, 1, 0, 0, 0, 7, 1, 1); cyc();
        set_id(1, 7, 7, 1, 1, 8, 1, 0); #1 chk("rs_stall", stall, 1);
        rst = 1; cyc();
        rst = 0; nop(); #1
        chk("rs_v1", v1, 0); chk("rs_v2", v2, 0); chk("rs_v3", v3, 0);
        chk("rs_nostall", stall, 0); chk("rs_count", count, 0); chk("rs_sat_count", sat_count, 0);

        // Four single-cycle load-use stalls: narrow counter must stick at all-ones
        repeat (4) begin
            set_id(1, 1, 0, 0, 0, 7, 1, 1); cyc();
            set_id(1, 7, 7, 1, 1, 8, 1, 0); cyc();
            cyc();
            nop();
        end
        #1 chk("sat_main", count, 4); chk("sat_narrow", sat_count, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
